// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RISC-V core.
// Covers the datapath width, the next-PC select encoding and the default reset/trap vectors.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JAL    = 3'd2,
        PC_JALR   = 3'd3,
        PC_TRAP   = 3'd4
    } pc_sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: priority select (jalr > jump > branch > seq),
// target adders and misaligned-target trap detection.
module pc_next_sel
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_branch,
    input  logic            i_branch_ne,
    input  logic            i_jump,
    input  logic            i_jalr,
    input  logic            i_zero,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_imm_ext,
    output pc_sel_t         o_pc_sel,
    output logic [XLEN-1:0] o_next_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_taken
);

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_rel_target;
    logic [XLEN-1:0] w_jalr_target;
    logic            w_branch_taken;
    logic [XLEN-1:0] w_target;
    logic            w_misaligned;
    pc_sel_t         w_raw_sel;

    assign w_pc_plus4     = i_pc + 32'd4;
    assign w_rel_target   = i_pc + i_imm_ext;
    assign w_jalr_target  = i_alu_result & ~32'h1;
    assign w_branch_taken = i_branch & (i_zero ^ i_branch_ne);

    // JALR clears bit 0 itself, so only bit 1 can make its target misaligned.
    always_comb begin
        w_raw_sel    = PC_SEQ;
        w_target     = w_pc_plus4;
        w_misaligned = 1'b0;
        if (i_jalr) begin
            w_raw_sel    = PC_JALR;
            w_target     = w_jalr_target;
            w_misaligned = w_jalr_target[1];
        end else if (i_jump) begin
            w_raw_sel    = PC_JAL;
            w_target     = w_rel_target;
            w_misaligned = |w_rel_target[1:0];
        end else if (w_branch_taken) begin
            w_raw_sel    = PC_BRANCH;
            w_target     = w_rel_target;
            w_misaligned = |w_rel_target[1:0];
        end
    end

    always_comb begin
        o_pc_sel  = w_raw_sel;
        o_next_pc = w_target;
        if (w_misaligned) begin
            o_pc_sel  = PC_TRAP;
            o_next_pc = TRAP_VECTOR;
        end
    end

    assign o_pc_plus4 = w_pc_plus4;
    assign o_taken    = (o_pc_sel != PC_SEQ);

endmodule

// File: rtl/pc_branch_unit.sv
// Program-counter and branch-resolution unit: holds the PC, the retired-instruction
// counter and the sticky misaligned-target flag; next-PC choice lives in pc_next_sel.
module pc_branch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            branch,
    input  logic            branch_ne,
    input  logic            jump,
    input  logic            jalr,
    input  logic            zero,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            taken,
    output logic            misaligned,
    output logic [XLEN-1:0] retired
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_retired;
    logic            r_misaligned;
    pc_sel_t         w_pc_sel;
    logic [XLEN-1:0] w_next_pc;

    pc_next_sel #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_pc_next_sel (
        .i_pc         (r_pc),
        .i_branch     (branch),
        .i_branch_ne  (branch_ne),
        .i_jump       (jump),
        .i_jalr       (jalr),
        .i_zero       (zero),
        .i_alu_result (alu_result),
        .i_imm_ext    (imm_ext),
        .o_pc_sel     (w_pc_sel),
        .o_next_pc    (w_next_pc),
        .o_pc_plus4   (pc_plus4),
        .o_taken      (taken)
    );

    // A trapped instruction redirects to the trap vector but does not retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_VECTOR;
            r_retired    <= '0;
            r_misaligned <= 1'b0;
        end else if (en) begin
            r_pc <= w_next_pc;
            if (w_pc_sel == PC_TRAP) begin
                r_misaligned <= 1'b1;
            end else begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign pc         = r_pc;
    assign retired    = r_retired;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit with hand-computed expected PC, counter and flag values.
module tb_pc_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        branch;
    logic        branch_ne;
    logic        jump;
    logic        jalr;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        taken;
    logic        misaligned;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    pc_branch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .branch     (branch),
        .branch_ne  (branch_ne),
        .jump       (jump),
        .jalr       (jalr),
        .zero       (zero),
        .alu_result (alu_result),
        .imm_ext    (imm_ext),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .taken      (taken),
        .misaligned (misaligned),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        branch = 0; branch_ne = 0; jump = 0; jalr = 0; zero = 0;
        alu_result = 0; imm_ext = 0;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc,
                             input logic [31:0] e_ret, input logic e_mis);
        chk({tag, "_pc"}, pc, e_pc);
        chk({tag, "_retired"}, retired, e_ret);
        chk({tag, "_misaligned"}, {31'd0, misaligned}, {31'd0, e_mis});
    endtask

    initial begin
        rst_n = 0; en = 0;
        idle();
        #3;
        chk_state("reset", 32'h0, 32'd0, 1'b0);
        chk("reset_pc_plus4", pc_plus4, 32'h4);
        chk("reset_taken_idle", {31'd0, taken}, 32'd0);
        branch = 1; zero = 1; imm_ext = 32'hFFFF_FFF8;
        #1;
        chk("reset_taken_follows", {31'd0, taken}, 32'd1);
        idle();
        en = 1;
        rst_n = 1;

        // Sequential flow after reset release
        step(); chk_state("seq1", 32'h4, 32'd1, 1'b0);
        step(); chk_state("seq2", 32'h8, 32'd2, 1'b0);
        step(); chk_state("seq3", 32'hC, 32'd3, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk_state("seq_to_20", 32'h20, 32'd8, 1'b0);

        // BEQ taken, imm=-8
        branch = 1; branch_ne = 0; zero = 1; imm_ext = 32'hFFFF_FFF8;
        #1 chk("beq_taken", {31'd0, taken}, 32'd1);
        step(); chk_state("beq_t", 32'h18, 32'd9, 1'b0);
        idle();
        step(); step(); chk("back_to_20", pc, 32'h20);

        // BEQ not taken
        branch = 1; branch_ne = 0; zero = 0; imm_ext = 32'hFFFF_FFF8;
        #1 chk("beq_nt_taken", {31'd0, taken}, 32'd0);
        step(); chk_state("beq_nt", 32'h24, 32'd12, 1'b0);

        // BNE taken from 0x24
        branch = 1; branch_ne = 1; zero = 0; imm_ext = 32'hFFFF_FFF8;
        #1 chk("bne_taken", {31'd0, taken}, 32'd1);
        step(); chk_state("bne_t", 32'h1C, 32'd13, 1'b0);

        // JALR with JAL also set: JALR wins, bit 0 cleared
        idle(); jalr = 1; jump = 1; alu_result = 32'h105; imm_ext = 32'h6;
        #1 chk("jalr_pc_plus4", pc_plus4, 32'h20);
        chk("jalr_taken", {31'd0, taken}, 32'd1);
        step(); chk_state("jalr", 32'h104, 32'd14, 1'b0);

        // JAL back to 0x40 (imm = 0x40 - 0x104)
        idle(); jump = 1; imm_ext = 32'hFFFF_FF3C;
        step(); chk_state("jal_to_40", 32'h40, 32'd15, 1'b0);

        // JAL misaligned trap
        imm_ext = 32'h6;
        #1 chk("jal_mis_taken", {31'd0, taken}, 32'd1);
        step(); chk_state("jal_trap", 32'h100, 32'd15, 1'b1);

        // Valid instruction after trap keeps the flag
        idle();
        step(); chk_state("after_trap", 32'h104, 32'd16, 1'b1);

        // Stall 5 edges with a jump pending
        en = 0; jump = 1; imm_ext = 32'h8;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_taken", {31'd0, taken}, 32'd1);
        end
        chk_state("stall", 32'h104, 32'd16, 1'b1);
        en = 1; idle();

        // JALR misaligned via bit 1
        jalr = 1; alu_result = 32'h203;
        step(); chk_state("jalr_trap", 32'h100, 32'd16, 1'b1);

        // Sequential wrap at top of address space
        idle(); jalr = 1; alu_result = 32'hFFFF_FFFC;
        step(); chk_state("to_top", 32'hFFFF_FFFC, 32'd17, 1'b1);
        idle();
        #1 chk("wrap_pc_plus4", pc_plus4, 32'h0);
        step(); chk_state("seq_wrap", 32'h0, 32'd18, 1'b1);

        // Branch target add wraps below zero
        branch = 1; zero = 1; imm_ext = 32'hFFFF_FFFC;
        step(); chk_state("br_wrap", 32'hFFFF_FFFC, 32'd19, 1'b1);
        idle();
        step(); chk("seq_wrap2", pc, 32'h0);

        // Async reset mid taken branch, before the next edge
        branch = 1; zero = 1; imm_ext = 32'h40;
        #2 rst_n = 0;
        #1 chk_state("async_rst", 32'h0, 32'd0, 1'b0);
        step(); chk_state("rst_held", 32'h0, 32'd0, 1'b0);
        chk("rst_held_taken", {31'd0, taken}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
